// File: rtl/knap_pkg.sv
// Shared types and sizes for the knapsack search engine.
package knap_pkg;
    localparam int N_ITEMS = 18;
    localparam int COEF_W  = 8;
    localparam int SUM_W   = 13;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [COEF_W-1:0] value;
        logic [COEF_W-1:0] weight;
        logic [COEF_W-1:0] volume;
    } coef_t;
endpackage

// File: rtl/knap_ctz18.sv
// Trailing-zero index of an 18-bit value; result is 0 for a zero input.
module knap_ctz18
    import knap_pkg::*;
(
    input  logic [N_ITEMS-1:0] value,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        idx = '0;
        // scan downwards so the lowest set bit is the final assignment
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (value[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/knap_search.sv
// Exhaustive Gray-order knapsack search: one candidate selection per RUN cycle.
//   state   | meaning
//   IDLE    | waiting for start; coefficient writes accepted
//   RUN     | evaluating one candidate per cycle
//   DONE    | one-cycle completion pulse, result valid
module knap_search
    import knap_pkg::*;
#(
    parameter int SEL_BITS = N_ITEMS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [COEF_W-1:0]   cfg_value,
    input  logic [COEF_W-1:0]   cfg_weight,
    input  logic [COEF_W-1:0]   cfg_volume,
    input  logic [SUM_W-1:0]    min_value,
    input  logic [SUM_W-1:0]    max_weight,
    input  logic [SUM_W-1:0]    max_volume,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                res_valid,
    output logic                found,
    output logic [N_ITEMS-1:0]  best_sel,
    output logic [SUM_W-1:0]    best_value
);
    localparam logic [N_ITEMS-1:0] LAST_CNT = N_ITEMS'((64'd1 << SEL_BITS) - 64'd1);

    state_t             state, state_nxt;
    coef_t              coef_ram [N_ITEMS];
    logic [SUM_W-1:0]   min_q, maxw_q, maxv_q;
    logic [SUM_W-1:0]   val_sum, wt_sum, vol_sum;
    logic [N_ITEMS-1:0] sel, cnt, cnt_nxt, tog_mask;
    logic [IDX_W-1:0]   tog_idx;
    logic               last_cnt, cand_pass, cand_better, adding, cfg_wr, take_start;
    coef_t              tog_coef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort)         state_nxt = ST_IDLE;
                else if (last_cnt) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign take_start = (state == ST_IDLE) && start;
    assign cfg_wr     = (state == ST_IDLE) && cfg_we && !start && (cfg_idx < IDX_W'(N_ITEMS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) coef_ram[i] <= '0;
        end else if (cfg_wr) begin
            coef_ram[cfg_idx] <= '{value: cfg_value, weight: cfg_weight, volume: cfg_volume};
        end
    end

    // Gray step: the bit that flips next is the trailing-zero index of cnt+1
    assign cnt_nxt  = cnt + N_ITEMS'(1);
    assign last_cnt = (cnt == LAST_CNT);

    knap_ctz18 u_ctz (
        .value (cnt_nxt),
        .idx   (tog_idx)
    );

    assign tog_mask    = N_ITEMS'(1) << tog_idx;
    assign tog_coef    = coef_ram[tog_idx];
    assign adding      = ~|(sel & tog_mask);
    assign cand_pass   = (val_sum >= min_q) && (wt_sum <= maxw_q) && (vol_sum <= maxv_q);
    assign cand_better = cand_pass && (!found || (val_sum > best_value));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q      <= '0;
            maxw_q     <= '0;
            maxv_q     <= '0;
            sel        <= '0;
            cnt        <= '0;
            val_sum    <= '0;
            wt_sum     <= '0;
            vol_sum    <= '0;
            best_sel   <= '0;
            best_value <= '0;
            found      <= 1'b0;
            res_valid  <= 1'b0;
        end else if (take_start) begin
            min_q      <= min_value;
            maxw_q     <= max_weight;
            maxv_q     <= max_volume;
            sel        <= '0;
            cnt        <= '0;
            val_sum    <= '0;
            wt_sum     <= '0;
            vol_sum    <= '0;
            best_sel   <= '0;
            best_value <= '0;
            found      <= 1'b0;
            res_valid  <= 1'b0;
        end else if ((state == ST_RUN) && !abort) begin
            // strict > keeps the earliest candidate on equal value
            if (cand_better) begin
                best_sel   <= sel;
                best_value <= val_sum;
                found      <= 1'b1;
            end
            if (last_cnt) begin
                res_valid <= 1'b1;
            end else begin
                cnt <= cnt_nxt;
                sel <= sel ^ tog_mask;
                if (adding) begin
                    val_sum <= val_sum + SUM_W'(tog_coef.value);
                    wt_sum  <= wt_sum  + SUM_W'(tog_coef.weight);
                    vol_sum <= vol_sum + SUM_W'(tog_coef.volume);
                end else begin
                    val_sum <= val_sum - SUM_W'(tog_coef.value);
                    wt_sum  <= wt_sum  - SUM_W'(tog_coef.weight);
                    vol_sum <= vol_sum - SUM_W'(tog_coef.volume);
                end
            end
        end
    end
endmodule

// File: tb/tb_knap_search.sv
// Bench for knap_search, using a reduced enumeration width to keep runs short.
module tb_knap_search;
    localparam int SB      = 12;
    localparam int RUN_LEN = 1 << SB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [7:0]  cfg_value = '0, cfg_weight = '0, cfg_volume = '0;
    logic [12:0] min_value = '0, max_weight = '0, max_volume = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic        busy, done, res_valid, found;
    logic [17:0] best_sel;
    logic [12:0] best_value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        f;
        logic [17:0] sel;
        logic [12:0] val;
    } exp_t;

    typedef struct {
        int          setup;
        logic [12:0] mn, mw, mv;
        logic        f;
        logic [17:0] sel;
        logic [12:0] val;
        int          mid_start;
        int          mid_cfg;
        bit          combo;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   cur_setup = -1;

    knap_search #(.SEL_BITS(SB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_value  (cfg_value),
        .cfg_weight (cfg_weight),
        .cfg_volume (cfg_volume),
        .min_value  (min_value),
        .max_weight (max_weight),
        .max_volume (max_volume),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .found      (found),
        .best_sel   (best_sel),
        .best_value (best_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(int i, int v, int w, int u);
        cfg_idx    = 5'(i);
        cfg_value  = 8'(v);
        cfg_weight = 8'(w);
        cfg_volume = 8'(u);
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic load(int s);
        for (int i = 0; i < 18; i++) begin
            if (s == 0 && i == 3)       wr(i, 20, 18, 4);
            else if (s == 0 && i == 10) wr(i, 30, 5, 5);
            else if (s == 1 && i < 2)   wr(i, 10, 40, 0);
            else                        wr(i, 0, 61, 0);
        end
        cur_setup = s;
    endtask

    task automatic run(vec_t v, int n);
        exp_t e;
        int   k;
        min_value  = v.mn;
        max_weight = v.mw;
        max_volume = v.mv;
        start = 1'b1;
        if (v.combo) begin
            abort = 1'b1;
            cfg_we = 1'b1; cfg_idx = 5'd3;
            cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
        end
        sb_q.push_back('{v.f, v.sel, v.val});
        tick();
        start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        // thresholds must have been captured at start
        min_value = '1; max_weight = '0; max_volume = '0;
        chk($sformatf("v%0d_busy", n), busy, 1);
        k = 1;
        while (!done && k <= RUN_LEN + 5) begin
            if (k == v.mid_start) start = 1'b1;
            if (k == v.mid_cfg) begin
                cfg_we = 1'b1; cfg_idx = 5'd3;
                cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
            end
            tick();
            start = 1'b0; cfg_we = 1'b0;
            k++;
        end
        chk($sformatf("v%0d_latency", n), k, RUN_LEN + 1);
        e = sb_q.pop_front();
        if (done) begin
            chk($sformatf("v%0d_busy_done", n), busy, 0);
            chk($sformatf("v%0d_res_valid", n), res_valid, 1);
            chk($sformatf("v%0d_found", n), found, e.f);
            chk($sformatf("v%0d_best_sel", n), best_sel, e.sel);
            chk($sformatf("v%0d_best_value", n), best_value, e.val);
            tick();
            tick();
            chk($sformatf("v%0d_done_pulse", n), done, 0);
            chk($sformatf("v%0d_hold_valid", n), res_valid, 1);
            chk($sformatf("v%0d_hold_sel", n), best_sel, e.sel);
        end else begin
            chk($sformatf("v%0d_done_timeout", n), done, 1);
        end
    endtask

    initial begin
        int k;
        int done_seen;

        vecs[0] = '{0, 13'd40, 13'd60, 13'd60, 1'b1, 18'h00408, 13'd50, 500, 700, 1'b0};
        vecs[1] = '{0, 13'd40, 13'd60, 13'd60, 1'b1, 18'h00408, 13'd50, 0, 0, 1'b1};
        vecs[2] = '{0, 13'd51, 13'd60, 13'd60, 1'b0, 18'h00000, 13'd0, 0, 0, 1'b0};
        vecs[3] = '{0, 13'd0,  13'd17, 13'd60, 1'b1, 18'h00400, 13'd30, 0, 0, 1'b0};
        vecs[4] = '{0, 13'd0,  13'd60, 13'd4,  1'b1, 18'h00008, 13'd20, 0, 0, 1'b0};
        vecs[5] = '{0, 13'd0,  13'd0,  13'd60, 1'b1, 18'h00000, 13'd0, 0, 0, 1'b0};
        vecs[6] = '{1, 13'd10, 13'd60, 13'd60, 1'b1, 18'h00001, 13'd10, 0, 0, 1'b0};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_found", found, 0);
        chk("rst_best_sel", best_sel, 0);
        chk("rst_best_value", best_value, 0);
        #20;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].setup != cur_setup) load(vecs[i].setup);
            run(vecs[i], i);
        end

        // abort at cycle 1000
        load(0);
        min_value = '0; max_weight = 13'd60; max_volume = 13'd60;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 1; k < 1000; k++) tick();
        chk("abort_busy_before", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        done_seen = 0;
        for (int j = 0; j < 20; j++) begin
            if (done) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_sb_empty", sb_q.size(), 0);

        // reset mid-run with found already set, then search with a cleared RAM
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 50; k++) tick();
        chk("prerst_found", found, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_found", found, 0);
        chk("midrst_best_sel", best_sel, 0);
        #12;
        rst_n = 1'b1;
        tick();
        cur_setup = -1;
        run('{-1, 13'd0, 13'd0, 13'd0, 1'b1, 18'h0, 13'd0, 0, 0, 1'b0}, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
